// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word request into one or two word
// accesses on a combinational-read data memory, then pulses a response.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t                state, state_next;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf0, buf1;

  logic                  handshake;
  logic                  legal;
  logic [3:0]            base_mask;
  logic [7:0]            mask;
  logic [63:0]           wide;
  logic                  split;
  logic [31:0]           rd_low;
  logic [31:0]           load_val;
  logic                  unused_addr;

  // Address bits above the memory range are intentionally dropped.
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  assign handshake = req_valid & req_ready;

  // Decode of the latched request: lane mask, lane-aligned data, load extraction.
  always_comb begin
    legal = is_legal(we_q, funct3_q);
    unique case (funct3_q[1:0])
      2'b00:   base_mask = 4'h1;
      2'b01:   base_mask = 4'h3;
      2'b10:   base_mask = 4'hF;
      default: base_mask = 4'h0;
    endcase
    mask   = {4'b0000, base_mask} << offset_q;
    wide   = {32'h0, wdata_q} << {offset_q, 3'b000};
    split  = |mask[7:4];
    rd_low = 32'({buf1, buf0} >> {offset_q, 3'b000});
    unique case (funct3_q)
      3'b000:  load_val = {{24{rd_low[7]}}, rd_low[7:0]};
      3'b001:  load_val = {{16{rd_low[15]}}, rd_low[15:0]};
      3'b100:  load_val = {24'h0, rd_low[7:0]};
      3'b101:  load_val = {16'h0, rd_low[15:0]};
      default: load_val = rd_low;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; illegal requests skip the memory phases entirely.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (handshake) state_next = is_legal(req_we, req_funct3) ? ACC0 : DONE;
      ACC0: state_next = split ? ACC1 : DONE;
      ACC1: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state; everything idles at zero.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_we     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: req_ready = rst_n;
      ACC0: begin
        mem_addr  = word_q;
        mem_we    = we_q ? mask[3:0] : 4'h0;
        mem_wdata = wide[31:0];
      end
      ACC1: begin
        mem_addr  = word_q + ADDR_WIDTH'(1);
        mem_we    = we_q ? mask[7:4] : 4'h0;
        mem_wdata = wide[63:32];
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = ~legal;
        resp_rdata = (legal && !we_q) ? load_val : '0;
      end
      default: ;
    endcase
  end

  // Request capture and read-data buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      offset_q <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      if (handshake) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        offset_q <= req_addr[1:0];
        word_q   <= req_addr[ADDR_WIDTH+1:2];
        wdata_q  <= req_wdata;
        buf0     <= '0;
        buf1     <= '0;
      end
      if (state == ACC0) buf0 <= mem_rdata;
      if (state == ACC1) buf1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: fixed vectors, bus-level corner sequences,
// and random traffic against a byte-addressed memory model.
module tb_load_store_unit;
  localparam int unsigned AW = 10;
  localparam int unsigned NWORDS = 1 << AW;
  localparam int unsigned NBYTES = NWORDS * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory seen by the DUT, with a backdoor write port for preloading.
  logic [31:0]   mem [0:NWORDS-1];
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Reference: flat byte array, little-endian.
  logic [7:0] ref_mem [0:NBYTES-1];

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_word(input int unsigned w, input logic [31:0] v);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = AW'(w); bd_data = v;
    @(posedge clk);
    #1 bd_en = 1'b0;
    for (int unsigned i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
  endtask

  task automatic check_word(input int unsigned w);
    logic [31:0] exp;
    exp = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    check($sformatf("mem word %0d", w), mem[w], exp);
  endtask

  // Behavioural model: byte-by-byte access, wrap at end of memory.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    int unsigned sz, ba;
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    rdata = 0; err = 0; lat = 1;
    if (!legal) begin
      err = 1;
      return;
    end
    sz = 1 << f3[1:0];
    ba = addr % NBYTES;
    lat = ((ba % 4) + sz > 4) ? 3 : 2;
    if (we) begin
      for (int unsigned i = 0; i < sz; i++) ref_mem[(ba+i) % NBYTES] = wdata[8*i +: 8];
    end else begin
      for (int unsigned i = 0; i < sz; i++) rdata[8*i +: 8] = ref_mem[(ba+i) % NBYTES];
      if (!f3[2] && sz < 4 && rdata[8*sz-1]) rdata = rdata | (32'hFFFF_FFFF << (8*sz));
    end
  endtask

  // Per-cycle bus trace of the most recent request (index = cycles after handshake).
  logic [AW-1:0] tr_addr  [0:8];
  logic [3:0]    tr_we    [0:8];
  logic [31:0]   tr_wdata [0:8];

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output logic clean,
                        output logic any_we);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    rdata = 0; err = 0; lat = 0; clean = 1; any_we = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tr_addr[k] = mem_addr; tr_we[k] = mem_we; tr_wdata[k] = mem_wdata;
      if (mem_we != 0) any_we = 1;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err;
        break;
      end else if (resp_rdata != 0 || resp_err) begin
        clean = 0;
      end
    end
  endtask

  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] rdata;
    logic err, clean, any_we;
    int lat;
    do_req(we, f3, addr, wdata, rdata, err, lat, clean, any_we);
    check({name, " rdata"}, rdata, exp_rdata);
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " idle resp zero"}, 32'(clean), 32'd1);
    if (exp_err || !we) check({name, " no write"}, 32'(any_we), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tab [0:10];

  initial begin
    logic [31:0] e_rdata;
    logic e_err;
    int e_lat;
    int bad_words;

    tab[0]  = '{1'b0, 3'b000, 32'h0000_0003, 32'h0, 32'hFFFF_FFDE, 1'b0, 2};
    tab[1]  = '{1'b0, 3'b100, 32'h0000_0003, 32'h0, 32'h0000_00DE, 1'b0, 2};
    tab[2]  = '{1'b0, 3'b010, 32'h0000_0013, 32'h0, 32'h0000_0500, 1'b0, 3};
    tab[3]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b1, 1};
    tab[4]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'hFFFF_DEAD, 1'b0, 2};
    tab[5]  = '{1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h0000_DEAD, 1'b0, 2};
    tab[6]  = '{1'b0, 3'b010, 32'hF000_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 2};
    tab[7]  = '{1'b1, 3'b011, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1};
    tab[8]  = '{1'b1, 3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b1, 1};
    tab[9]  = '{1'b0, 3'b110, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1};
    tab[10] = '{1'b0, 3'b001, 32'h0000_0003, 32'h0, 32'h0000_78DE, 1'b0, 3};

    // Preload memory while held in reset.
    for (int unsigned w = 0; w < NWORDS; w++) set_word(w, $urandom);
    set_word(0, 32'hDEAD_BEEF);
    set_word(1, 32'h1234_5678);
    set_word(4, 32'h0000_0004);
    set_word(5, 32'h0000_0005);

    @(negedge clk);
    req_valid = 1'b1;
    #1;
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset outputs", {resp_rdata[27:0], mem_we}, 32'd0);
    check("reset mem_addr/wdata", mem_wdata | 32'(mem_addr) | 32'(resp_err), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1 check("ready after reset", 32'(req_ready), 32'd1);

    for (int i = 0; i <= 10; i++)
      run_req($sformatf("vec%0d", i), tab[i].we, tab[i].f3, tab[i].addr, tab[i].wdata,
              tab[i].rdata, tab[i].err, tab[i].lat);

    // Split halfword store across words 1/2.
    model(1'b1, 3'b001, 32'h007, 32'h0000_ABCD, e_rdata, e_err, e_lat);
    run_req("st_h_0x007", 1'b1, 3'b001, 32'h007, 32'h0000_ABCD, 32'h0, 1'b0, 3);
    check("st_h acc0 addr", 32'(tr_addr[1]), 32'd1);
    check("st_h acc0 we", 32'(tr_we[1]), 32'h8);
    check("st_h acc0 wdata", tr_wdata[1], 32'hCD00_0000);
    check("st_h acc1 addr", 32'(tr_addr[2]), 32'd2);
    check("st_h acc1 we", 32'(tr_we[2]), 32'h1);
    check("st_h acc1 wdata", tr_wdata[2], 32'h0000_00AB);
    check_word(1);
    check_word(2);

    // Split word store wrapping from top word to word 0.
    model(1'b1, 3'b010, 32'hFFD, 32'h1122_3344, e_rdata, e_err, e_lat);
    run_req("st_w_0xffd", 1'b1, 3'b010, 32'hFFD, 32'h1122_3344, 32'h0, 1'b0, 3);
    check("st_w acc0 addr", 32'(tr_addr[1]), 32'd1023);
    check("st_w acc0 we", 32'(tr_we[1]), 32'hE);
    check("st_w acc0 wdata", tr_wdata[1], 32'h2233_4400);
    check("st_w acc1 addr", 32'(tr_addr[2]), 32'd0);
    check("st_w acc1 we", 32'(tr_we[2]), 32'h1);
    check("st_w acc1 wdata", tr_wdata[2], 32'h0000_0011);
    check_word(1023);
    check_word(0);

    // Same store, reset asserted during the second access.
    set_word(1023, 32'hAAAA_AAAA);
    set_word(0, 32'h5555_5555);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'hFFD; req_wdata = 32'h1122_3344;
    check("abort ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort acc0 we", 32'(mem_we), 32'hE);
    @(negedge clk);
    check("abort acc1 addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort outputs zero", {mem_wdata[23:0], mem_we, 2'b00, req_ready, resp_valid}, 32'd0);
    check("abort addr zero", 32'(mem_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort no resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    #1 check("abort ready after release", 32'(req_ready), 32'd1);
    ref_mem[4093] = 8'h44; ref_mem[4094] = 8'h33; ref_mem[4095] = 8'h22;
    check("abort word1023", mem[1023], 32'h2233_44AA);
    check("abort word0", mem[0], 32'h5555_5555);

    // Random traffic against the byte model.
    for (int n = 0; n < 400; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wdata;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_wdata = $urandom;
      if ($urandom_range(0, 7) == 0) r_addr[11:0] = 12'hFFC + 12'($urandom_range(0, 3));
      model(r_we, r_f3, r_addr, r_wdata, e_rdata, e_err, e_lat);
      run_req($sformatf("rnd%0d", n), r_we, r_f3, r_addr, r_wdata, e_rdata, e_err, e_lat);
      if (r_we && !e_err) begin
        check_word(int'(r_addr[11:2]));
        check_word((int'(r_addr[11:2]) + 1) % NWORDS);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    bad_words = 0;
    for (int unsigned w = 0; w < NWORDS; w++)
      if (mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]})
        bad_words++;
    check("final memory words differing", 32'(bad_words), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the memory data width; only 32 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL flag a request.
REQ-006 req_ready  output  1  SHALL flag that the unit accepts a request this cycle.
REQ-007 req_we  input  1  SHALL select store (1) or load (0).
REQ-008 req_funct3  input  3  SHALL be the RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  32  SHALL be the byte address; bits above ADDR_WIDTH+1 are ignored.
REQ-010 req_wdata  input  32  SHALL be the store data, right-aligned.
REQ-011 resp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-012 resp_rdata  output  32  SHALL be the extended load result.
REQ-013 resp_err  output  1  SHALL flag an illegal funct3; it is valid with resp_valid.
REQ-014 mem_we  output  4  SHALL be the per-byte write enables to data memory.
REQ-015 mem_addr  output  ADDR_WIDTH  SHALL be the word address to data memory.
REQ-016 mem_wdata  output  32  SHALL be the lane-aligned write data.
REQ-017 mem_rdata  input  32  SHALL be the memory read data, combinational from mem_addr in the same cycle.

Function
REQ-018 The FSM SHALL have the states IDLE, ACC0, ACC1 and DONE.
REQ-019 req_ready SHALL be 1 only in IDLE with rst_n high.
REQ-020 On a handshake (req_valid & req_ready), the unit SHALL latch we, funct3, offset = addr[1:0], word = addr[ADDR_WIDTH+1:2] and wdata.
REQ-021 On the same handshake, the FSM SHALL go to ACC0, or to DONE if funct3 is illegal.
REQ-022 For loads, legal funct3 SHALL be 000, 001, 010, 100 and 101.
REQ-023 For stores, legal funct3 SHALL be 000, 001 and 010; all other codes are illegal.
REQ-024 Size SHALL be 1, 2 or 4 bytes.
REQ-025 Define the 8-bit mask M = (1, 3 or F) << offset and the 64-bit word W = zext(wdata) << (8*offset).
REQ-026 An access SHALL be split when M[7:4] != 0.
REQ-027 In ACC0, mem_addr SHALL be word.
REQ-028 In ACC0, mem_we SHALL be M[3:0] for a store and 0 for a load.
REQ-029 In ACC0, mem_wdata SHALL be W[31:0] and buf0 SHALL capture mem_rdata.
REQ-030 From ACC0, the FSM SHALL go to ACC1 if the access is split, else to DONE.
REQ-031 In ACC1, mem_addr SHALL be (word+1) mod 2^ADDR_WIDTH, so the address wraps from the top word to 0.
REQ-032 In ACC1, mem_we SHALL be M[7:4] for a store and 0 for a load.
REQ-033 In ACC1, mem_wdata SHALL be W[63:32] and buf1 SHALL capture mem_rdata; the FSM then goes to DONE.
REQ-034 In IDLE and DONE, mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-035 In DONE, resp_valid SHALL be 1 and the FSM SHALL return to IDLE next cycle; there is no response backpressure.
REQ-036 A load result SHALL be R = ({buf1, buf0} >> (8*offset)), low size bytes, sign-extended for B/H and zero-extended for BU/HU; buf1 is 0 if the access is not split.
REQ-037 For stores and errors, resp_rdata SHALL be 0.
REQ-038 resp_rdata and resp_err SHALL be 0 whenever resp_valid is 0.
REQ-039 Latency from the handshake edge to resp_valid SHALL be 2 cycles for an unsplit access, 3 for a split access and 1 for an illegal funct3.
REQ-040 An illegal request SHALL never assert mem_we.
REQ-041 A request presented while req_ready is 0 SHALL be ignored; the requester holds it.

Reset
REQ-042 While rst_n is low, the FSM SHALL be in IDLE and all outputs SHALL be 0, including req_ready.
REQ-043 Buffers and latched fields SHALL clear to 0 on reset.
REQ-044 A reset asserted mid-operation SHALL abort the access immediately, with no response pulse.
REQ-045 After a split store is aborted in ACC1, the ACC0 bytes remain written; this is accepted behaviour.
REQ-046 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-047 Load B at 0x003 with word0=0xDEADBEEF -> resp_rdata 0xFFFFFFDE; BU -> 0x000000DE; resp_valid 2 cycles after the handshake.
REQ-048 Load W at 0x013 with word4=0x00000004 and word5=0x00000005 -> mem_addr 4 then 5, resp_rdata 0x00000500, resp_valid 3 cycles after the handshake.
REQ-049 Store H 0x0000ABCD at 0x007 -> ACC0 addr 1, we 1000, wdata 0xCD000000; ACC1 addr 2, we 0001, wdata 0x000000AB.
REQ-050 Store W 0x11223344 at 0xFFD (ADDR_WIDTH=10) -> ACC0 addr 1023, we 1110, wdata 0x22334400; ACC1 addr 0, we 0001, wdata 0x00000011.
REQ-051 Load funct3=011 at 0x000 -> resp_valid 1 cycle after the handshake, resp_err 1, resp_rdata 0, mem_we 0 throughout.
REQ-052 rst_n low during ACC1 of the REQ-050 store -> outputs 0 at once, no resp_valid, word1023 bytes 3..1 updated, word0 unchanged, req_ready 1 in the first cycle after release.
